// File: rtl/tdc_sequencer.sv
// Carry-chain TDC sequencer: arm, coarse count, capture, fine encode, handshake, drain.
// Optional `TDC_BUBBLE_FILTER_EN applies a 3-tap majority filter at capture.
module tdc_sequencer #(
    parameter int CHAIN_LEN    = 200,
    parameter int FINE_W       = 8,
    parameter int COARSE_W     = 16,
    parameter int SEG          = 8,
    parameter int CLEAR_CYCLES = 4
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 arm,
    input  logic [CHAIN_LEN-1:0] therm_in,
    output logic                 chain_en,
    output logic                 busy,
    output logic                 res_valid,
    input  logic                 res_ready,
    output logic [FINE_W-1:0]    res_fine,
    output logic [COARSE_W-1:0]  res_coarse,
    output logic                 res_ovf,
    output logic                 res_timeout
);

    localparam int NSEG = (CHAIN_LEN - 1 + SEG - 1) / SEG;
    localparam int SIW  = $clog2(NSEG + 1);
    localparam int CW   = $clog2(CLEAR_CYCLES + 1);
    localparam int PADW = NSEG * SEG;

    typedef enum logic [2:0] {
        S_IDLE, S_ARMED, S_ENCODE, S_OUT, S_CLEAR
    } state_t;

    state_t               state, state_n;
    logic [COARSE_W-1:0]  coarse, coarse_n;
    logic [CHAIN_LEN-1:0] snap, snap_n, cap;
    logic [SIW-1:0]       seg_idx, seg_idx_n;
    logic [FINE_W-1:0]    acc, acc_n, acc_sat;
    logic [CW-1:0]        clr_cnt, clr_cnt_n;
    logic                 chain_en_n, res_valid_n, res_ovf_n, res_timeout_n;
    logic [FINE_W-1:0]    res_fine_n;
    logic [COARSE_W-1:0]  res_coarse_n;
    logic [PADW-1:0]      padded;
    logic [SEG-1:0]       seg_bits;
    logic [FINE_W:0]      zc, sum;
    logic                 hit, idle_pat;

`ifdef TDC_BUBBLE_FILTER_EN
    logic [CHAIN_LEN:0] ext;
    assign ext = {therm_in, 1'b0};
    always_comb begin
        cap = therm_in;
        for (int i = 0; i < CHAIN_LEN - 1; i++)
            cap[i] = (ext[i] & ext[i+1]) | (ext[i] & ext[i+2]) |
                     (ext[i+1] & ext[i+2]);
    end
`else
    assign cap = therm_in;
`endif

    assign hit      = ~therm_in[0];
    assign idle_pat = therm_in[0] & ~therm_in[CHAIN_LEN-1];
    assign busy     = (state != S_IDLE);

    // Pad with ones so bits at or above the MSB never count as zeros.
    always_comb begin
        padded = '1;
        padded[CHAIN_LEN-2:0] = snap[CHAIN_LEN-2:0];
        seg_bits = padded[seg_idx*SEG +: SEG];
        zc = '0;
        for (int j = 0; j < SEG; j++)
            zc = zc + {{FINE_W{1'b0}}, ~seg_bits[j]};
        sum = {1'b0, acc} + zc;
        acc_sat = sum[FINE_W] ? '1 : sum[FINE_W-1:0];
    end

    always_comb begin
        state_n       = state;
        coarse_n      = coarse;
        snap_n        = snap;
        seg_idx_n     = seg_idx;
        acc_n         = acc;
        clr_cnt_n     = clr_cnt;
        chain_en_n    = chain_en;
        res_valid_n   = res_valid;
        res_fine_n    = res_fine;
        res_coarse_n  = res_coarse;
        res_ovf_n     = res_ovf;
        res_timeout_n = res_timeout;
        unique case (state)
            S_IDLE: begin
                if (arm) begin
                    state_n    = S_ARMED;
                    coarse_n   = '0;
                    chain_en_n = 1'b1;
                end
            end
            S_ARMED: begin
                if (hit) begin
                    state_n    = S_ENCODE;
                    snap_n     = cap;
                    chain_en_n = 1'b0;
                    seg_idx_n  = '0;
                    acc_n      = '0;
                end else if (coarse != '1) begin
                    coarse_n = coarse + 1'b1;
                end else begin
                    state_n       = S_OUT;
                    chain_en_n    = 1'b0;
                    res_valid_n   = 1'b1;
                    res_timeout_n = 1'b1;
                    res_fine_n    = '0;
                    res_ovf_n     = 1'b0;
                    res_coarse_n  = coarse;
                end
            end
            S_ENCODE: begin
                acc_n     = acc_sat;
                seg_idx_n = seg_idx + 1'b1;
                if (seg_idx == SIW'(NSEG - 1)) begin
                    state_n       = S_OUT;
                    res_valid_n   = 1'b1;
                    res_fine_n    = acc_sat;
                    res_ovf_n     = snap[CHAIN_LEN-1];
                    res_coarse_n  = coarse;
                    res_timeout_n = 1'b0;
                end
            end
            S_OUT: begin
                if (res_ready) begin
                    state_n     = S_CLEAR;
                    res_valid_n = 1'b0;
                    clr_cnt_n   = '0;
                end
            end
            S_CLEAR: begin
                if (!idle_pat) begin
                    clr_cnt_n = '0;
                end else if (clr_cnt == CW'(CLEAR_CYCLES - 1)) begin
                    state_n   = S_IDLE;
                    clr_cnt_n = '0;
                end else begin
                    clr_cnt_n = clr_cnt + 1'b1;
                end
            end
            default: state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state       <= S_IDLE;
            coarse      <= '0;
            snap        <= '0;
            seg_idx     <= '0;
            acc         <= '0;
            clr_cnt     <= '0;
            chain_en    <= 1'b0;
            res_valid   <= 1'b0;
            res_fine    <= '0;
            res_coarse  <= '0;
            res_ovf     <= 1'b0;
            res_timeout <= 1'b0;
        end else begin
            state       <= state_n;
            coarse      <= coarse_n;
            snap        <= snap_n;
            seg_idx     <= seg_idx_n;
            acc         <= acc_n;
            clr_cnt     <= clr_cnt_n;
            chain_en    <= chain_en_n;
            res_valid   <= res_valid_n;
            res_fine    <= res_fine_n;
            res_coarse  <= res_coarse_n;
            res_ovf     <= res_ovf_n;
            res_timeout <= res_timeout_n;
        end
    end

endmodule

// File: tb/tb_tdc_sequencer.sv
// Self-checking bench for tdc_sequencer: vector table, hand sequences, random hits.
// Expected fine codes follow the optional bubble filter when TDC_BUBBLE_FILTER_EN is set.
module tb_tdc_sequencer;

    localparam int CL = 200;

    logic          clk, rstn;
    logic          arm, res_ready, arm4, ready4;
    logic [CL-1:0] therm, therm4;
    logic          chain_en, busy, res_valid, res_ovf, res_timeout;
    logic [7:0]    res_fine;
    logic [15:0]   res_coarse;
    logic          chain_en4, busy4, valid4, ovf4, tmo4;
    logic [7:0]    fine4;
    logic [3:0]    coarse4;

    int checks = 0;
    int failures = 0;

    logic [CL-1:0] idle_v;
    assign idle_v = {1'b0, {(CL-1){1'b1}}};

    tdc_sequencer dut (
        .clk(clk), .rstn(rstn), .arm(arm), .therm_in(therm),
        .chain_en(chain_en), .busy(busy), .res_valid(res_valid),
        .res_ready(res_ready), .res_fine(res_fine),
        .res_coarse(res_coarse), .res_ovf(res_ovf),
        .res_timeout(res_timeout)
    );

    tdc_sequencer #(.COARSE_W(4)) dut4 (
        .clk(clk), .rstn(rstn), .arm(arm4), .therm_in(therm4),
        .chain_en(chain_en4), .busy(busy4), .res_valid(valid4),
        .res_ready(ready4), .res_fine(fine4),
        .res_coarse(coarse4), .res_ovf(ovf4),
        .res_timeout(tmo4)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic logic [CL-1:0] mk(input int nz, input bit msb);
        logic [CL-1:0] v;
        for (int i = 0; i < CL - 1; i++) v[i] = (i >= nz);
        v[CL-1] = msb;
        return v;
    endfunction

    // Reference: count zeros below the MSB, after optional majority filtering.
    function automatic int model_fine(input logic [CL-1:0] v);
        logic [CL-1:0] s;
        int a, b, c, n;
        s = v;
`ifdef TDC_BUBBLE_FILTER_EN
        for (int i = 0; i < CL - 1; i++) begin
            if (i > 0) a = int'(v[i-1]);
            else a = 0;
            b = int'(v[i]);
            c = int'(v[i+1]);
            s[i] = ((a + b + c) >= 2);
        end
`endif
        n = 0;
        for (int i = 0; i < CL - 1; i++) if (!s[i]) n++;
        return n;
    endfunction

    task automatic run_to_valid(input string name, input logic [CL-1:0] hv,
                                input int dly, input bit noise);
        int n;
        @(negedge clk);
        arm = 1'b1;
        therm = idle_v;
        @(negedge clk);
        arm = 1'b0;
        check({name, "/chain_en_armed"}, chain_en, 1);
        check({name, "/busy_armed"}, busy, 1);
        repeat (dly) @(negedge clk);
        therm = hv;
        @(negedge clk);
        therm = idle_v;
        check({name, "/chain_en_cap"}, chain_en, 0);
        n = 0;
        while (!res_valid && n < 40) begin
            if (noise) begin
                arm = ~arm;
                res_ready = arm;
            end
            @(negedge clk);
            n++;
        end
        arm = 1'b0;
        res_ready = 1'b0;
        check({name, "/latency"}, n, 25);
    endtask

    task automatic measure(input string name, input logic [CL-1:0] hv,
                           input int dly, input int rw, input bit noise,
                           input int efine, input bit eovf);
        int n;
        bit stable;
        run_to_valid(name, hv, dly, noise);
        check({name, "/fine"}, res_fine, efine);
        check({name, "/coarse"}, res_coarse, dly);
        check({name, "/ovf"}, res_ovf, eovf);
        check({name, "/timeout"}, res_timeout, 0);
        check({name, "/chain_en"}, chain_en, 0);
        stable = 1'b1;
        for (int k = 0; k < rw; k++) begin
            if (noise) arm = 1'b1;
            @(negedge clk);
            arm = 1'b0;
            if (res_valid !== 1'b1 || res_fine !== 8'(efine) ||
                res_coarse !== 16'(dly) || res_ovf !== eovf ||
                res_timeout !== 1'b0 || busy !== 1'b1)
                stable = 1'b0;
        end
        check({name, "/hold"}, stable, 1);
        res_ready = 1'b1;
        @(negedge clk);
        res_ready = 1'b0;
        check({name, "/valid_drop"}, res_valid, 0);
        check({name, "/busy_clear"}, busy, 1);
        n = 0;
        while (busy && n < 20) begin
            @(negedge clk);
            n++;
        end
        check({name, "/clear_len"}, n, 4);
        check({name, "/idle_chain_en"}, chain_en, 0);
    endtask

    typedef struct {
        logic [CL-1:0] hv;
        int            dly;
        int            rw;
        bit            noise;
        int            fine;
        bit            ovf;
    } vec_t;

    vec_t vecs[7];

    initial begin
        logic [CL-1:0] hv;
        logic [CL-1:0] bub;
        int n;
        int bub_fine;

        rstn = 1'b0;
        arm = 1'b0;
        res_ready = 1'b0;
        therm = idle_v;
        arm4 = 1'b0;
        ready4 = 1'b0;
        therm4 = {1'b0, {(CL-1){1'b1}}};

        bub = mk(20, 0);
        bub[10] = 1'b1;
`ifdef TDC_BUBBLE_FILTER_EN
        bub_fine = 20;
`else
        bub_fine = 19;
`endif
        vecs[0] = '{mk(37, 0), 5, 0, 1'b0, 37, 1'b0};
        vecs[1] = '{mk(199, 1), 0, 3, 1'b0, 199, 1'b1};
        vecs[2] = '{mk(1, 0), 0, 1, 1'b0, 1, 1'b0};
        vecs[3] = '{mk(8, 0), 2, 0, 1'b1, 8, 1'b0};
        vecs[4] = '{mk(9, 1), 7, 10, 1'b1, 9, 1'b1};
        vecs[5] = '{mk(199, 0), 3, 2, 1'b0, 199, 1'b0};
        vecs[6] = '{bub, 4, 1, 1'b0, bub_fine, 1'b0};

        repeat (2) @(negedge clk);
        check("rst/chain_en", chain_en, 0);
        check("rst/busy", busy, 0);
        check("rst/valid", res_valid, 0);
        check("rst/fine", res_fine, 0);
        check("rst/coarse", res_coarse, 0);
        check("rst/ovf", res_ovf, 0);
        check("rst/timeout", res_timeout, 0);
        rstn = 1'b1;

        for (int v = 0; v < 7; v++)
            measure($sformatf("vec%0d", v), vecs[v].hv, vecs[v].dly,
                    vecs[v].rw, vecs[v].noise, vecs[v].fine, vecs[v].ovf);

        // Coarse saturation on the narrow instance.
        @(negedge clk);
        arm4 = 1'b1;
        @(negedge clk);
        arm4 = 1'b0;
        n = 0;
        while (!valid4 && n < 40) begin
            @(negedge clk);
            n++;
        end
        check("tmo/latency", n, 16);
        check("tmo/timeout", tmo4, 1);
        check("tmo/coarse", coarse4, 15);
        check("tmo/fine", fine4, 0);
        check("tmo/ovf", ovf4, 0);
        check("tmo/chain_en", chain_en4, 0);
        ready4 = 1'b1;
        @(negedge clk);
        ready4 = 1'b0;
        check("tmo/valid_drop", valid4, 0);
        n = 0;
        while (busy4 && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("tmo/clear_len", n, 4);

        // Interrupted idle run in CLEAR restarts the count.
        run_to_valid("clr", mk(60, 0), 2, 1'b0);
        check("clr/fine", res_fine, model_fine(mk(60, 0)));
        res_ready = 1'b1;
        @(negedge clk);
        res_ready = 1'b0;
        repeat (3) @(negedge clk);
        check("clr/busy_3idle", busy, 1);
        therm = mk(5, 0);
        @(negedge clk);
        therm = idle_v;
        check("clr/busy_nonidle", busy, 1);
        repeat (3) @(negedge clk);
        check("clr/busy_3more", busy, 1);
        @(negedge clk);
        check("clr/idle", busy, 0);

        // Reset in the middle of ENCODE discards the result.
        @(negedge clk);
        arm = 1'b1;
        @(negedge clk);
        arm = 1'b0;
        repeat (2) @(negedge clk);
        therm = mk(50, 1);
        @(negedge clk);
        therm = idle_v;
        repeat (10) @(negedge clk);
        check("mrst/busy_pre", busy, 1);
        rstn = 1'b0;
        @(negedge clk);
        rstn = 1'b1;
        check("mrst/chain_en", chain_en, 0);
        check("mrst/busy", busy, 0);
        check("mrst/valid", res_valid, 0);
        check("mrst/fine", res_fine, 0);
        check("mrst/coarse", res_coarse, 0);
        check("mrst/ovf", res_ovf, 0);
        check("mrst/timeout", res_timeout, 0);
        measure("post_rst", mk(3, 0), 1, 0, 1'b0, 3, 1'b0);

        for (int r = 0; r < 20; r++) begin
            for (int w = 0; w < CL; w += 32)
                for (int b = 0; b < 32 && w + b < CL; b++)
                    hv[w+b] = 1'($urandom_range(0, 1));
            hv[0] = 1'b0;
            measure($sformatf("rnd%0d", r), hv,
                    int'($urandom_range(0, 12)),
                    int'($urandom_range(0, 4)),
                    1'($urandom_range(0, 1)),
                    model_fine(hv), hv[CL-1]);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
